udp_eth_tx: RTL and testbench
=============================

UDP_ETH_TX -- requirements
Module: udp_eth_tx

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 RST_N  in  1  reset; asynchronous assert, active-low.
REQ-004 udpConfig_put  in  144  {mac[143:96], ip[95:64], netMask[63:32], gateWay[31:0]}.
REQ-005 EN_udpConfig_put  in  1 / RDY_udpConfig_put  out  1  config write strobe / ready.
REQ-006 udpMetaDataInTx_put  in  80  {dataLen[79:64], dstIp[63:32], dstPort[31:16], srcPort[15:0]}.
REQ-007 EN_udpMetaDataInTx_put  in  1 / RDY_udpMetaDataInTx_put  out  1.
REQ-008 macMetaDataInTx_put  in  64  {dstMac[63:16], ethType[15:0]}.
REQ-009 EN_macMetaDataInTx_put  in  1 / RDY_macMetaDataInTx_put  out  1.
REQ-010 dataStreamInTx_put  in  290  {data[289:34], byteEn[33:2], isFirst[1], isLast[0]}; byte i of a beat is data[8i+7:8i].
REQ-011 EN_dataStreamInTx_put  in  1 / RDY_dataStreamInTx_put  out  1.
REQ-012 axiStreamOutTx_first  out  578  {tData[577:66], tKeep[65:2], tUser[1], tLast[0]}; head of output FIFO.
REQ-013 RDY_axiStreamOutTx_first, RDY_axiStreamOutTx_deq, axiStreamOutTx_notEmpty  out  1  all equal output-FIFO-not-empty; RDY_axiStreamOutTx_notEmpty  out  1  constant 1 outside reset.
REQ-014 EN_axiStreamOutTx_deq  in  1  pops output head; asserted only when RDY_axiStreamOutTx_deq=1.

Function
REQ-015 Every EN_* is asserted only while its RDY_* is 1; a transfer occurs on a cycle with EN=1.
REQ-016 Config: RDY_udpConfig_put always 1; a write stores all four fields and sets "configured"; a later write overwrites them. netMask and gateWay are stored only.
REQ-017 RDY_udpMetaDataInTx_put = configured AND 2-entry udp-meta FIFO not full; RDY_macMetaDataInTx_put = 2-entry mac-meta FIFO not full.
REQ-018 Each frame consumes exactly one udp-meta entry, one mac-meta entry and one input beat sequence (isFirst .. isLast); header generation stalls until both meta entries are present.
REQ-019 Frame byte stream = 14B Ethernet + 20B IPv4 + 8B UDP header (42 bytes) + payload bytes; multi-byte header fields big-endian; frame byte 0 at tData[7:0].
REQ-020 Ethernet: dst=dstMac, src=config mac, type=ethType.
REQ-021 IPv4: 0x45, TOS 0x00, totalLen=dataLen+28, id 0x0000, flags/frag 0x0000, TTL 64, protocol 17, header checksum = ones-complement of 16-bit ones-complement sum of the header (checksum field taken as 0), src=config ip, dst=dstIp.
REQ-022 UDP: srcPort, dstPort, length=dataLen+8, checksum 0x0000. Lengths are 16-bit modulo arithmetic.
REQ-023 Payload bytes are packed contiguously: byteEn is LSB-contiguous; only enabled bytes are forwarded; no gaps, no Ethernet padding, no FCS.
REQ-024 Output beats: every beat except the last has tKeep all-ones; last beat has tLast=1, tKeep=(1<<n)-1 with n=((42+payload) mod 64, 64 if zero). tUser=0 always.
REQ-025 Frame end is determined by isLast; dataLen is used only in header fields and must equal the enabled byte count (mismatch: frame still ends at isLast, headers carry dataLen).
REQ-026 Sustained rate: one input beat per cycle when output is not back-pressured; output FIFO depth 2; RDY_dataStreamInTx_put drops only on back-pressure or missing meta for a new frame.
REQ-027 Latency: first output beat visible no earlier than 1 and no later than 3 cycles after the beat completing it is accepted.
REQ-028 Back-to-back frames: the next frame's header may start the cycle after the previous frame's last input beat; frames never share an output beat.

Reset
REQ-029 While RST_N=0: all FIFOs empty, configured=0, packer state idle; all RDY_* and notEmpty 0; axiStreamOutTx_first 0.
REQ-030 Reset mid-frame discards partial frame and all pending metadata; config must be rewritten.

Structure
REQ-031 Package udp_eth_pkg: field widths, header byte lengths (14/20/8/42), TTL, protocol, bus widths (256/32, 512/64).
REQ-032 One sub-module ip_checksum (combinational 20-byte header sum/fold/invert); FIFOs as the codebase's standard FIFO.

Verification
REQ-033 Config mac 02:00:00:00:00:01, ip 192.168.1.1; meta dstIp 192.168.1.2, dataLen 22 -> one beat, tKeep all-ones, tLast=1, totalLen 0x0032, IP checksum 0xF767.
REQ-034 dataLen 23 -> two beats; beat 2 tKeep=0x1, tLast=1.
REQ-035 dataLen 100 (4 input beats) -> three beats; last tKeep=0x3FFF; totalLen 0x0080, UDP length 0x006C.
REQ-036 udp meta offered before any config -> RDY_udpMetaDataInTx_put=0 until config written.
REQ-037 Two back-to-back frames with random EN_axiStreamOutTx_deq stalls -> bytes match reference model, no loss/duplication.
REQ-038 RST_N low mid-frame -> all RDY/notEmpty 0; after release, a fresh config + frame is transmitted correctly.

Source files
------------

// File: rtl/udp_eth_pkg.sv
// Shared widths, header constants and beat layouts for the UDP/IPv4/Ethernet transmit path.
package udp_eth_pkg;
    localparam int MAC_W         = 48;
    localparam int IP_W          = 32;
    localparam int PORT_W        = 16;
    localparam int LEN_W         = 16;
    localparam int ETH_HDR_BYTES = 14;
    localparam int IP_HDR_BYTES  = 20;
    localparam int UDP_HDR_BYTES = 8;
    localparam int HDR_BYTES     = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
    localparam logic [7:0] IP_TTL       = 8'd64;
    localparam logic [7:0] IP_PROTO_UDP = 8'd17;
    localparam int IN_DATA_W  = 256;
    localparam int IN_KEEP_W  = 32;
    localparam int OUT_DATA_W = 512;
    localparam int OUT_KEEP_W = 64;
    // Worst case the packer holds 63 leftover bytes plus one full input beat.
    localparam int ACC_BYTES  = OUT_KEEP_W + IN_KEEP_W;
    localparam int CNT_W      = 7;
    localparam int CFG_W      = 144;
    localparam int UDP_META_W = 80;
    localparam int MAC_META_W = 64;
    localparam int OUT_BEAT_W = 578;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FLUSH} tx_state_e;

    typedef struct packed {
        logic [MAC_W-1:0] mac;
        logic [IP_W-1:0]  ip;
        logic [IP_W-1:0]  net_mask;
        logic [IP_W-1:0]  gate_way;
    } udp_cfg_t;

    typedef struct packed {
        logic [LEN_W-1:0]  data_len;
        logic [IP_W-1:0]   dst_ip;
        logic [PORT_W-1:0] dst_port;
        logic [PORT_W-1:0] src_port;
    } udp_meta_t;

    typedef struct packed {
        logic [MAC_W-1:0] dst_mac;
        logic [15:0]      eth_type;
    } mac_meta_t;

    typedef struct packed {
        logic [IN_DATA_W-1:0] data;
        logic [IN_KEEP_W-1:0] byte_en;
        logic                 is_first;
        logic                 is_last;
    } in_beat_t;

    typedef struct packed {
        logic [OUT_DATA_W-1:0] t_data;
        logic [OUT_KEEP_W-1:0] t_keep;
        logic                  t_user;
        logic                  t_last;
    } out_beat_t;

    function automatic logic [OUT_KEEP_W-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [OUT_KEEP_W-1:0] m;
        for (int i = 0; i < OUT_KEEP_W; i++) m[i] = (CNT_W'(i) < n);
        return m;
    endfunction
endpackage

// File: rtl/ip_checksum.sv
// Combinational IPv4 header checksum: 16-bit ones-complement sum of 20 bytes, folded and inverted.
module ip_checksum
    import udp_eth_pkg::*;
(
    input  logic [8*IP_HDR_BYTES-1:0] hdr,
    output logic [15:0]               csum
);
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = '0;
        for (int i = 0; i < IP_HDR_BYTES / 2; i++) sum = sum + 20'(hdr[16*i +: 16]);
        fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);
        csum  = ~fold2;
    end
endmodule

// File: rtl/udp_eth_fifo.sv
// Two-entry FIFO; head reads as zero while empty.
module udp_eth_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/udp_eth_tx.sv
// UDP/IPv4/Ethernet framer: prepends a 42-byte header to a 32-byte-wide payload stream
// and repacks the result into gap-free 64-byte output beats.
module udp_eth_tx
    import udp_eth_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [CFG_W-1:0]      udpConfig_put,
    input  logic                  EN_udpConfig_put,
    output logic                  RDY_udpConfig_put,
    input  logic [UDP_META_W-1:0] udpMetaDataInTx_put,
    input  logic                  EN_udpMetaDataInTx_put,
    output logic                  RDY_udpMetaDataInTx_put,
    input  logic [MAC_META_W-1:0] macMetaDataInTx_put,
    input  logic                  EN_macMetaDataInTx_put,
    output logic                  RDY_macMetaDataInTx_put,
    input  logic [289:0]          dataStreamInTx_put,
    input  logic                  EN_dataStreamInTx_put,
    output logic                  RDY_dataStreamInTx_put,
    output logic [OUT_BEAT_W-1:0] axiStreamOutTx_first,
    output logic                  RDY_axiStreamOutTx_first,
    input  logic                  EN_axiStreamOutTx_deq,
    output logic                  RDY_axiStreamOutTx_deq,
    output logic                  axiStreamOutTx_notEmpty,
    output logic                  RDY_axiStreamOutTx_notEmpty
);
    logic                   alive_q, alive_d, configured_q, configured_d;
    udp_cfg_t               cfg_q, cfg_d;
    tx_state_e              state_q, state_d;
    logic [8*ACC_BYTES-1:0] acc_q, acc_d, base_buf, merged_buf;
    logic [CNT_W-1:0]       cnt_q, cnt_d, base_cnt, merged_cnt, in_count;
    udp_meta_t              udp_head;
    mac_meta_t              mac_head;
    in_beat_t               in_beat;
    out_beat_t              out_din;
    logic                   udp_full, udp_empty, mac_full, mac_empty, out_full, out_empty;
    logic                   udp_push, mac_push, meta_pop, in_rdy, in_accept, out_push;
    logic [15:0]            ip_total_len, udp_len, ip_csum;
    logic [8*IP_HDR_BYTES-1:0] ip_csum_in;
    logic [8*HDR_BYTES-1:0] hdr_be, hdr_le;
    logic [IN_DATA_W-1:0]   in_data_m;
    logic                   unused_bits;

    udp_eth_fifo #(.W(UDP_META_W)) u_udp_meta (
        .clk(CLK), .rst_n(RST_N), .push(udp_push), .din(udpMetaDataInTx_put),
        .pop(meta_pop), .dout(udp_head), .full(udp_full), .empty(udp_empty));
    udp_eth_fifo #(.W(MAC_META_W)) u_mac_meta (
        .clk(CLK), .rst_n(RST_N), .push(mac_push), .din(macMetaDataInTx_put),
        .pop(meta_pop), .dout(mac_head), .full(mac_full), .empty(mac_empty));
    udp_eth_fifo #(.W(OUT_BEAT_W)) u_out (
        .clk(CLK), .rst_n(RST_N), .push(out_push), .din(out_din),
        .pop(EN_axiStreamOutTx_deq), .dout(axiStreamOutTx_first), .full(out_full), .empty(out_empty));

    assign ip_total_len = udp_head.data_len + 16'd28;
    assign udp_len      = udp_head.data_len + 16'd8;
    assign ip_csum_in   = {8'h45, 8'h00, ip_total_len, 16'h0000, 16'h0000, IP_TTL, IP_PROTO_UDP,
                           16'h0000, cfg_q.ip, udp_head.dst_ip};
    ip_checksum u_csum (.hdr(ip_csum_in), .csum(ip_csum));

    assign hdr_be = {mac_head.dst_mac, cfg_q.mac, mac_head.eth_type,
                     8'h45, 8'h00, ip_total_len, 16'h0000, 16'h0000, IP_TTL, IP_PROTO_UDP,
                     ip_csum, cfg_q.ip, udp_head.dst_ip,
                     udp_head.src_port, udp_head.dst_port, udp_len, 16'h0000};

    // Frame byte 0 is the first header byte on the wire but must sit in the lowest lane.
    for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr_swap
        assign hdr_le[8*gi +: 8] = hdr_be[8*(HDR_BYTES-1-gi) +: 8];
    end
    for (genvar gi = 0; gi < IN_KEEP_W; gi++) begin : g_in_mask
        assign in_data_m[8*gi +: 8] = in_beat.byte_en[gi] ? in_beat.data[8*gi +: 8] : 8'h00;
    end

    assign in_beat     = in_beat_t'(dataStreamInTx_put);
    assign in_count    = CNT_W'($countones(in_beat.byte_en));
    assign in_rdy      = alive_q && !out_full &&
                         ((state_q == ST_DATA) || (state_q == ST_IDLE && !udp_empty && !mac_empty));
    assign in_accept   = EN_dataStreamInTx_put && in_rdy;
    // The header is merged with the frame's first beat, so both metas retire on that beat.
    assign meta_pop    = in_accept && (state_q == ST_IDLE);
    assign udp_push    = EN_udpMetaDataInTx_put && RDY_udpMetaDataInTx_put;
    assign mac_push    = EN_macMetaDataInTx_put && RDY_macMetaDataInTx_put;
    assign unused_bits = ^{cfg_q.net_mask, cfg_q.gate_way, in_beat.is_first};

    assign RDY_udpConfig_put           = alive_q;
    assign RDY_udpMetaDataInTx_put     = alive_q && configured_q && !udp_full;
    assign RDY_macMetaDataInTx_put     = alive_q && !mac_full;
    assign RDY_dataStreamInTx_put      = in_rdy;
    assign axiStreamOutTx_notEmpty     = !out_empty;
    assign RDY_axiStreamOutTx_first    = !out_empty;
    assign RDY_axiStreamOutTx_deq      = !out_empty;
    assign RDY_axiStreamOutTx_notEmpty = alive_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin : p_merge
        base_buf   = (state_q == ST_IDLE) ? {{(8*(ACC_BYTES-HDR_BYTES)){1'b0}}, hdr_le} : acc_q;
        base_cnt   = (state_q == ST_IDLE) ? CNT_W'(HDR_BYTES) : cnt_q;
        merged_buf = base_buf | ({{(8*(ACC_BYTES-IN_KEEP_W)){1'b0}}, in_data_m} << {base_cnt, 3'b000});
        merged_cnt = base_cnt + in_count;
    end

    always_comb begin : p_next
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DATA:
                if (in_accept)
                    state_d = !in_beat.is_last ? ST_DATA :
                              (merged_cnt > 7'd64) ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: if (!out_full) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin : p_out
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_push = 1'b0;
        out_din  = '0;
        if (in_accept) begin
            if (merged_cnt > 7'd64 || (merged_cnt == 7'd64 && !in_beat.is_last)) begin
                out_push       = 1'b1;
                out_din.t_data = merged_buf[OUT_DATA_W-1:0];
                out_din.t_keep = '1;
                acc_d          = merged_buf >> OUT_DATA_W;
                cnt_d          = merged_cnt - 7'd64;
            end else if (in_beat.is_last) begin
                out_push       = 1'b1;
                out_din.t_data = merged_buf[OUT_DATA_W-1:0];
                out_din.t_keep = keep_mask(merged_cnt);
                out_din.t_last = 1'b1;
                acc_d          = '0;
                cnt_d          = '0;
            end else begin
                acc_d = merged_buf;
                cnt_d = merged_cnt;
            end
        end else if (state_q == ST_FLUSH && !out_full) begin
            out_push       = 1'b1;
            out_din.t_data = acc_q[OUT_DATA_W-1:0];
            out_din.t_keep = keep_mask(cnt_q);
            out_din.t_last = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
        end
    end

    always_comb begin : p_cfg
        alive_d      = 1'b1;
        cfg_d        = cfg_q;
        configured_d = configured_q;
        if (EN_udpConfig_put && alive_q) begin
            cfg_d        = udp_cfg_t'(udpConfig_put);
            configured_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alive_q      <= 1'b0;
            configured_q <= 1'b0;
            cfg_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
        end else begin
            alive_q      <= alive_d;
            configured_q <= configured_d;
            cfg_q        <= cfg_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_udp_eth_tx.sv
// Scoreboard bench for udp_eth_tx: a byte-level frame model predicts every output beat.
module tb_udp_eth_tx;
    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [143:0] udpConfig_put = '0;
    logic         EN_udpConfig_put = 1'b0, RDY_udpConfig_put;
    logic [79:0]  udpMetaDataInTx_put = '0;
    logic         EN_udpMetaDataInTx_put = 1'b0, RDY_udpMetaDataInTx_put;
    logic [63:0]  macMetaDataInTx_put = '0;
    logic         EN_macMetaDataInTx_put = 1'b0, RDY_macMetaDataInTx_put;
    logic [289:0] dataStreamInTx_put = '0;
    logic         EN_dataStreamInTx_put = 1'b0, RDY_dataStreamInTx_put;
    logic [577:0] axiStreamOutTx_first;
    logic         RDY_axiStreamOutTx_first, RDY_axiStreamOutTx_deq;
    logic         EN_axiStreamOutTx_deq = 1'b0;
    logic         axiStreamOutTx_notEmpty, RDY_axiStreamOutTx_notEmpty;

    always #5 CLK = ~CLK;

    udp_eth_tx dut (
        .CLK(CLK), .RST_N(RST_N),
        .udpConfig_put(udpConfig_put), .EN_udpConfig_put(EN_udpConfig_put),
        .RDY_udpConfig_put(RDY_udpConfig_put),
        .udpMetaDataInTx_put(udpMetaDataInTx_put), .EN_udpMetaDataInTx_put(EN_udpMetaDataInTx_put),
        .RDY_udpMetaDataInTx_put(RDY_udpMetaDataInTx_put),
        .macMetaDataInTx_put(macMetaDataInTx_put), .EN_macMetaDataInTx_put(EN_macMetaDataInTx_put),
        .RDY_macMetaDataInTx_put(RDY_macMetaDataInTx_put),
        .dataStreamInTx_put(dataStreamInTx_put), .EN_dataStreamInTx_put(EN_dataStreamInTx_put),
        .RDY_dataStreamInTx_put(RDY_dataStreamInTx_put),
        .axiStreamOutTx_first(axiStreamOutTx_first), .RDY_axiStreamOutTx_first(RDY_axiStreamOutTx_first),
        .EN_axiStreamOutTx_deq(EN_axiStreamOutTx_deq), .RDY_axiStreamOutTx_deq(RDY_axiStreamOutTx_deq),
        .axiStreamOutTx_notEmpty(axiStreamOutTx_notEmpty),
        .RDY_axiStreamOutTx_notEmpty(RDY_axiStreamOutTx_notEmpty));

    typedef struct {
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [31:0] dip;
        logic [15:0] dport;
        logic [15:0] sport;
        logic [15:0] dlen;
        int          plen;
    } frame_t;

    int           n_tests = 0, n_fail = 0, beats_seen = 0, stall_pct = 0;
    logic [577:0] sb_q [$];
    logic [47:0]  cfg_mac = 48'h02_00_00_00_00_01;
    logic [31:0]  cfg_ip  = {8'd192, 8'd168, 8'd1, 8'd1};
    logic         sink_en = 1'b0, sink_in_frame = 1'b0;
    logic [577:0] hdr_beat = '0, last_beat = '0;

    task automatic check(input string tag, input logic [577:0] got, input logic [577:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] field16(input logic [577:0] beat, input int i);
        return {beat[66+8*i +: 8], beat[66+8*(i+1) +: 8]};
    endfunction

    function automatic frame_t mk_frame(input int plen);
        frame_t f;
        f.dmac  = {16'h0a0b, 32'($urandom)};
        f.etype = 16'h0800;
        f.dip   = {8'd192, 8'd168, 8'd1, 8'd2};
        f.dport = 16'($urandom_range(1024, 65535));
        f.sport = 16'($urandom_range(1024, 65535));
        f.dlen  = 16'(plen);
        f.plen  = plen;
        return f;
    endfunction

    task automatic expect_frame(input frame_t f, input byte unsigned pay[$]);
        byte unsigned fr[$], ip[$];
        logic [15:0]  tl, ul, cs;
        logic [31:0]  s;
        logic [511:0] d;
        logic [63:0]  k;
        tl = f.dlen + 16'd28;
        ul = f.dlen + 16'd8;
        ip = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h00, 8'h00, 8'd64, 8'd17, 8'h00, 8'h00,
               cfg_ip[31:24], cfg_ip[23:16], cfg_ip[15:8], cfg_ip[7:0],
               f.dip[31:24], f.dip[23:16], f.dip[15:8], f.dip[7:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s = s + {16'h0, ip[2*i], ip[2*i+1]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        cs = ~s[15:0];
        ip[10] = cs[15:8];
        ip[11] = cs[7:0];
        for (int i = 5; i >= 0; i--) fr.push_back(f.dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(cfg_mac[8*i +: 8]);
        fr.push_back(f.etype[15:8]);
        fr.push_back(f.etype[7:0]);
        foreach (ip[i]) fr.push_back(ip[i]);
        fr.push_back(f.sport[15:8]); fr.push_back(f.sport[7:0]);
        fr.push_back(f.dport[15:8]); fr.push_back(f.dport[7:0]);
        fr.push_back(ul[15:8]);      fr.push_back(ul[7:0]);
        fr.push_back(8'h00);         fr.push_back(8'h00);
        foreach (pay[i]) fr.push_back(pay[i]);
        for (int b = 0; b < fr.size(); b += 64) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 64; j++)
                if (b + j < fr.size()) begin
                    d[8*j +: 8] = fr[b+j];
                    k[j] = 1'b1;
                end
            sb_q.push_back({d, k, 1'b0, (b + 64 >= fr.size())});
        end
    endtask

    task automatic write_cfg();
        udpConfig_put = {cfg_mac, cfg_ip, 32'hffffff00, {8'd192, 8'd168, 8'd1, 8'd254}};
        EN_udpConfig_put = 1'b1;
        @(negedge CLK);
        EN_udpConfig_put = 1'b0;
    endtask

    task automatic put_meta(input frame_t f);
        int t = 0;
        while (!(RDY_udpMetaDataInTx_put && RDY_macMetaDataInTx_put) && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) check("meta_rdy_timeout", 1'b0, 1'b1);
        udpMetaDataInTx_put = {f.dlen, f.dip, f.dport, f.sport};
        macMetaDataInTx_put = {f.dmac, f.etype};
        EN_udpMetaDataInTx_put = 1'b1;
        EN_macMetaDataInTx_put = 1'b1;
        @(negedge CLK);
        EN_udpMetaDataInTx_put = 1'b0;
        EN_macMetaDataInTx_put = 1'b0;
    endtask

    task automatic put_data(input frame_t f, input int max_beats, input bit track);
        byte unsigned pay[$];
        int           nb, cnt, t;
        logic [255:0] d;
        logic [32:0]  be_w;
        for (int i = 0; i < f.plen; i++) pay.push_back(8'($urandom_range(255)));
        if (track) expect_frame(f, pay);
        nb = (f.plen + 31) / 32;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            cnt  = (f.plen - 32*b > 32) ? 32 : f.plen - 32*b;
            be_w = (33'd1 << cnt) - 33'd1;
            for (int j = 0; j < 32; j++) d[8*j +: 8] = (j < cnt) ? pay[32*b+j] : 8'($urandom_range(255));
            t = 0;
            while (!RDY_dataStreamInTx_put && t < 200) begin
                @(negedge CLK);
                t++;
            end
            if (t >= 200) check("data_rdy_timeout", 1'b0, 1'b1);
            dataStreamInTx_put = {d, be_w[31:0], (b == 0), (b == nb - 1)};
            EN_dataStreamInTx_put = 1'b1;
            @(negedge CLK);
            EN_dataStreamInTx_put = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((sb_q.size() != 0 || axiStreamOutTx_notEmpty) && t < 1000) begin
            @(negedge CLK);
            t++;
        end
        check(tag, 578'(sb_q.size()), 578'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy_cfg"},  RDY_udpConfig_put, 1'b0);
        check({tag, "_rdy_udp"},  RDY_udpMetaDataInTx_put, 1'b0);
        check({tag, "_rdy_mac"},  RDY_macMetaDataInTx_put, 1'b0);
        check({tag, "_rdy_data"}, RDY_dataStreamInTx_put, 1'b0);
        check({tag, "_notempty"}, axiStreamOutTx_notEmpty, 1'b0);
        check({tag, "_rdy_ne"},   RDY_axiStreamOutTx_notEmpty, 1'b0);
        check({tag, "_first"},    axiStreamOutTx_first, '0);
    endtask

    // Output sink: pops the DUT head (with optional random stalls) and compares it with the scoreboard.
    initial begin
        logic [577:0] exp_beat;
        forever begin
            @(negedge CLK);
            EN_axiStreamOutTx_deq = 1'b0;
            if (sink_en && axiStreamOutTx_notEmpty && ($urandom_range(99) >= stall_pct)) begin
                if (sb_q.size() == 0) begin
                    check("extra_beat", 1'b1, 1'b0);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check($sformatf("beat%0d", beats_seen), axiStreamOutTx_first, exp_beat);
                end
                $display("[TB] beat %0d keep=%h last=%0d", beats_seen,
                         axiStreamOutTx_first[65:2], axiStreamOutTx_first[0]);
                if (!sink_in_frame) hdr_beat = axiStreamOutTx_first;
                sink_in_frame = !axiStreamOutTx_first[0];
                last_beat = axiStreamOutTx_first;
                beats_seen++;
                EN_axiStreamOutTx_deq = 1'b1;
            end
        end
    end

    initial begin
        frame_t fa, fb;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Metadata must be refused until a configuration has been written.
        for (int i = 0; i < 3; i++) begin
            check("udp_rdy_unconfigured", RDY_udpMetaDataInTx_put, 1'b0);
            @(negedge CLK);
        end
        check("mac_rdy_unconfigured", RDY_macMetaDataInTx_put, 1'b1);
        check("cfg_rdy", RDY_udpConfig_put, 1'b1);
        write_cfg();
        check("udp_rdy_configured", RDY_udpMetaDataInTx_put, 1'b1);
        sink_en = 1'b1;

        fa = mk_frame(22);
        put_meta(fa);
        put_data(fa, 99, 1'b1);
        drain("drain_len22");
        check("len22_keep", last_beat[65:2], {64{1'b1}});
        check("len22_last", last_beat[0], 1'b1);
        check("len22_user", last_beat[1], 1'b0);
        check("len22_total_len", field16(hdr_beat, 16), 16'h0032);
        check("len22_ip_csum", field16(hdr_beat, 24), 16'hF767);

        fa = mk_frame(23);
        put_meta(fa);
        put_data(fa, 99, 1'b1);
        drain("drain_len23");
        check("len23_keep", last_beat[65:2], 64'h1);
        check("len23_last", last_beat[0], 1'b1);

        fa = mk_frame(100);
        put_meta(fa);
        put_data(fa, 99, 1'b1);
        drain("drain_len100");
        check("len100_keep", last_beat[65:2], 64'h3FFF);
        check("len100_total_len", field16(hdr_beat, 16), 16'h0080);
        check("len100_udp_len", field16(hdr_beat, 38), 16'h006C);

        // Back-to-back frames with random output stalls, then a few random lengths.
        stall_pct = 40;
        fa = mk_frame(50);
        fb = mk_frame(130);
        put_meta(fa);
        put_meta(fb);
        put_data(fa, 99, 1'b1);
        put_data(fb, 99, 1'b1);
        for (int i = 0; i < 4; i++) begin
            fa = mk_frame($urandom_range(1, 150));
            put_meta(fa);
            put_data(fa, 99, 1'b1);
        end
        drain("drain_b2b");
        stall_pct = 0;

        // Reset in the middle of a frame, then a fresh configuration and frame.
        sink_en = 1'b0;
        fa = mk_frame(120);
        put_meta(fa);
        put_data(fa, 2, 1'b0);
        RST_N = 1'b0;
        #1;
        check_idle_outputs("midreset");
        sb_q.delete();
        sink_in_frame = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("udp_rdy_after_reset", RDY_udpMetaDataInTx_put, 1'b0);
        sink_en = 1'b1;
        write_cfg();
        fa = mk_frame(60);
        put_meta(fa);
        put_data(fa, 99, 1'b1);
        drain("drain_after_reset");
        check("after_reset_total_len", field16(hdr_beat, 16), 16'd88);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
